// File: rtl/pe_row_ctrl.sv
// rtl/pe_row_ctrl.sv - sequencer for a 3-tap MAC PE computing one row of a 1-D valid convolution
module pe_row_ctrl #(
  parameter int DATA_BITS     = 16,
  parameter int INTERNAL_BITS = 32,
  parameter int ADDR_BITS     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITS-1:0]     len,
  input  logic [ADDR_BITS-1:0]     w_base,
  input  logic [ADDR_BITS-1:0]     if_base,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_ren,
  output logic [ADDR_BITS-1:0]     mem_addr,
  input  logic [DATA_BITS-1:0]     mem_rdata,
  output logic                     pe_w_w,
  output logic                     pe_if_w,
  output logic [DATA_BITS-1:0]     pe_w_in,
  output logic [DATA_BITS-1:0]     pe_if_in,
  input  logic [INTERNAL_BITS-1:0] pe_result,
  output logic                     out_valid,
  output logic [INTERNAL_BITS-1:0] out_data,
  output logic [ADDR_BITS-1:0]     out_addr
);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_IF, DRAIN, FIN} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] len_q;
  logic [ADDR_BITS-1:0] if_base_q;
  logic                 relu_q;
  logic [ADDR_BITS-1:0] cnt;
  logic [ADDR_BITS-1:0] if_idx;
  logic [ADDR_BITS-1:0] out_cnt;
  logic                 cap_pend;

  // Buffer data goes straight to the PE; the strobes carry the read-valid timing.
  assign pe_w_in  = mem_rdata;
  assign pe_if_in = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
      pe_w_w    <= 1'b0;
      pe_if_w   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      len_q     <= '0;
      if_base_q <= '0;
      relu_q    <= 1'b0;
      cnt       <= '0;
      if_idx    <= '0;
      out_cnt   <= '0;
      cap_pend  <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      pe_w_w    <= mem_ren && (state == LOAD_W);
      pe_if_w   <= mem_ren && (state == LOAD_IF);
      // The window is full once feature 2 is written; the result settles the next cycle.
      cap_pend  <= pe_if_w && (if_idx >= ADDR_BITS'(2));
      if (pe_if_w)
        if_idx <= if_idx + 1'b1;
      if (cap_pend) begin
        out_valid <= 1'b1;
        out_data  <= (relu_q && pe_result[INTERNAL_BITS-1]) ? '0 : pe_result;
        out_addr  <= out_cnt;
        out_cnt   <= out_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            len_q     <= len;
            if_base_q <= if_base;
            relu_q    <= relu_en;
            cnt       <= '0;
            if_idx    <= '0;
            out_cnt   <= '0;
            if (len < ADDR_BITS'(3)) begin
              state <= FIN;
            end else begin
              state    <= LOAD_W;
              mem_ren  <= 1'b1;
              mem_addr <= w_base;
            end
          end
        end
        LOAD_W: begin
          if (cnt == ADDR_BITS'(2)) begin
            state    <= LOAD_IF;
            mem_addr <= if_base_q;
            cnt      <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        LOAD_IF: begin
          if (cnt == len_q - 1'b1) begin
            state   <= DRAIN;
            mem_ren <= 1'b0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Last capture: a capture is pending and no further feature write follows it.
          if (cap_pend && !pe_if_w)
            state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
